// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types: response codes, channel FSM states
// and the byte-strobe merge used by the register bank.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        WS_IDLE,
        WS_HAVE_AW,
        WS_HAVE_W,
        WS_RESP
    } wr_state_t;

    typedef enum logic {
        RS_IDLE,
        RS_RESP
    } rd_state_t;

    function automatic logic [31:0] strb_merge(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite register-file responder: RW control words plus one
// read-only status word, one outstanding write and one outstanding read.
module axi_lite_slave_regfile
    import axi_lite_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter int          NUM_REGS  = 8,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ADDR_W-1:0]     AWADDR,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [31:0]           WDATA,
    input  logic [3:0]            WSTRB,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ADDR_W-1:0]     ARADDR,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [31:0]           RDATA,
    output logic [1:0]            RRESP,
    output logic                  RVALID,
    input  logic                  RREADY,
    input  logic [31:0]           status_in,
    output logic [NUM_REGS*32-1:0] reg_out,
    output logic [NUM_REGS-1:0]   reg_wr_pulse
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REGS - 1);

    wr_state_t ws, ws_nxt;
    rd_state_t rs, rs_nxt;

    logic [ADDR_W-1:0] aw_addr_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;
    logic [31:0]       regs [NUM_REGS];

    logic              aw_fire, w_fire, ar_fire, commit;
    logic [ADDR_W-1:0] wa;
    logic [31:0]       wd;
    logic [3:0]        wstrb_eff;
    logic [IDX_W-1:0]  w_idx, r_idx;
    logic              w_ok, r_ok;

    // Handshake outputs are decoded from state and forced low in reset
    assign AWREADY = !areset && (ws == WS_IDLE || ws == WS_HAVE_W);
    assign WREADY  = !areset && (ws == WS_IDLE || ws == WS_HAVE_AW);
    assign BVALID  = !areset && (ws == WS_RESP);
    assign ARREADY = !areset && (rs == RS_IDLE);
    assign RVALID  = !areset && (rs == RS_RESP);

    assign aw_fire = AWVALID && AWREADY;
    assign w_fire  = WVALID && WREADY;
    assign ar_fire = ARVALID && ARREADY;

    always_comb begin
        ws_nxt = ws;
        case (ws)
            WS_IDLE: begin
                if (aw_fire && w_fire) ws_nxt = WS_RESP;
                else if (aw_fire)      ws_nxt = WS_HAVE_AW;
                else if (w_fire)       ws_nxt = WS_HAVE_W;
            end
            WS_HAVE_AW: if (w_fire)  ws_nxt = WS_RESP;
            WS_HAVE_W:  if (aw_fire) ws_nxt = WS_RESP;
            WS_RESP:    if (BREADY)  ws_nxt = WS_IDLE;
            default:    ws_nxt = WS_IDLE;
        endcase
    end

    always_comb begin
        rs_nxt = rs;
        case (rs)
            RS_IDLE: if (ar_fire) rs_nxt = RS_RESP;
            RS_RESP: if (RREADY)  rs_nxt = RS_IDLE;
            default: rs_nxt = RS_IDLE;
        endcase
    end

    // Whichever half arrived first comes from its holding register
    assign commit    = (ws != WS_RESP) && (ws_nxt == WS_RESP);
    assign wa        = (ws == WS_HAVE_AW) ? aw_addr_q : AWADDR;
    assign wd        = (ws == WS_HAVE_W) ? w_data_q : WDATA;
    assign wstrb_eff = (ws == WS_HAVE_W) ? w_strb_q : WSTRB;

    assign w_idx = wa[ADDR_W-1:2];
    assign r_idx = ARADDR[ADDR_W-1:2];
    assign w_ok  = (wa[1:0] == 2'b00) && (w_idx < LAST);
    assign r_ok  = (ARADDR[1:0] == 2'b00) && (r_idx <= LAST);

    always_ff @(posedge aclk) begin
        if (areset) begin
            ws           <= WS_IDLE;
            rs           <= RS_IDLE;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            BRESP        <= OKAY;
            RRESP        <= OKAY;
            RDATA        <= '0;
            reg_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else begin
            ws           <= ws_nxt;
            rs           <= rs_nxt;
            reg_wr_pulse <= '0;
            if (aw_fire) aw_addr_q <= AWADDR;
            if (w_fire) begin
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end
            if (commit) begin
                BRESP <= w_ok ? OKAY : SLVERR;
                if (w_ok) begin
                    regs[w_idx[SEL_W-1:0]] <=
                        strb_merge(regs[w_idx[SEL_W-1:0]], wd, wstrb_eff);
                    reg_wr_pulse[w_idx[SEL_W-1:0]] <= 1'b1;
                end
            end
            // Sampled before this edge's write lands, so a collision reads old data
            if (ar_fire) begin
                RRESP <= r_ok ? OKAY : SLVERR;
                if (!r_ok)              RDATA <= '0;
                else if (r_idx == LAST) RDATA <= status_in;
                else                    RDATA <= regs[r_idx[SEL_W-1:0]];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign reg_out[32*g +: 32] = regs[g];
    end

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Randomized bench for the AXI-Lite register file with a word-array
// reference model and a per-cycle register/pulse compare.
module tb_axi_lite_slave_regfile;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic [11:0]  AWADDR = '0;
    logic         AWVALID = 1'b0;
    logic         AWREADY;
    logic [31:0]  WDATA = '0;
    logic [3:0]   WSTRB = '0;
    logic         WVALID = 1'b0;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY = 1'b0;
    logic [11:0]  ARADDR = '0;
    logic         ARVALID = 1'b0;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY = 1'b0;
    logic [31:0]  status_in = '0;
    logic [255:0] reg_out;
    logic [7:0]   reg_wr_pulse;

    axi_lite_slave_regfile dut (
        .aclk(aclk), .areset(areset),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .status_in(status_in), .reg_out(reg_out),
        .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 aclk = ~aclk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m [8];
    logic [7:0]  exp_pulse = '0;
    bit          run = 1'b0;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] flat();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = m[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m[i] = 32'h0;
        exp_pulse = '0;
    endtask

    always @(negedge aclk) begin
        if (run && !areset) begin
            chk("reg_out", reg_out, flat());
            chk("reg_wr_pulse", {248'h0, reg_wr_pulse}, {248'h0, exp_pulse});
        end
    end

    task automatic wr(input logic [11:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input int awd, input int wdl,
                      input int bd, output logic [1:0] resp,
                      output logic [7:0] pulse);
        bit  awdone = 0, wdone = 0, af, wf, legal;
        int  cyc = 0;
        int  idx;
        logic [1:0] eresp;
        idx   = int'(addr) / 4;
        legal = (addr % 4 == 0) && (idx < 7);
        eresp = legal ? 2'b00 : 2'b10;
        resp  = 2'bxx;
        pulse = 'x;
        AWADDR = addr; WDATA = data; WSTRB = strb;
        while (!(awdone && wdone)) begin
            AWVALID = !awdone && cyc >= awd;
            WVALID  = !wdone && cyc >= wdl;
            @(negedge aclk);
            af = AWVALID && AWREADY;
            wf = WVALID && WREADY;
            if (awdone && !wdone) chk("awready_hold", AWREADY, 0);
            if (wdone && !awdone) chk("wready_hold", WREADY, 0);
            @(posedge aclk); #1;
            if (af) awdone = 1;
            if (wf) wdone = 1;
            cyc++;
            if (cyc > 50) begin
                chk("wr_timeout", 1, 0);
                AWVALID = 0; WVALID = 0;
                return;
            end
        end
        AWVALID = 0; WVALID = 0;
        if (legal) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) m[idx][8*b +: 8] = data[8*b +: 8];
            exp_pulse = 8'(1 << idx);
        end
        for (int i = 0; i <= bd; i++) begin
            BREADY = (i == bd);
            @(negedge aclk);
            if (i == 0) pulse = reg_wr_pulse;
            chk("bvalid", BVALID, 1);
            chk("bresp", BRESP, eresp);
            chk("awready_in_resp", AWREADY, 0);
            chk("wready_in_resp", WREADY, 0);
            resp = BRESP;
            @(posedge aclk); #1;
            exp_pulse = '0;
        end
        BREADY = 0;
    endtask

    task automatic rd(input logic [11:0] addr, input int ard, input int rdl,
                      output logic [31:0] data, output logic [1:0] resp);
        bit af = 0, legal;
        int cyc = 0;
        int idx;
        logic [31:0] edata;
        logic [1:0]  eresp;
        idx   = int'(addr) / 4;
        legal = (addr % 4 == 0) && (idx < 8);
        edata = 'x; eresp = 'x;
        data = 'x; resp = 'x;
        ARADDR = addr;
        while (!af) begin
            ARVALID = cyc >= ard;
            @(negedge aclk);
            af = ARVALID && ARREADY;
            if (af) begin
                eresp = legal ? 2'b00 : 2'b10;
                edata = !legal ? 32'h0 : (idx == 7) ? status_in : m[idx];
            end
            @(posedge aclk); #1;
            cyc++;
            if (!af && cyc > 50) begin
                chk("rd_timeout", 1, 0);
                ARVALID = 0;
                return;
            end
        end
        ARVALID = 0;
        for (int i = 0; i <= rdl; i++) begin
            RREADY = (i == rdl);
            @(negedge aclk);
            chk("rvalid", RVALID, 1);
            chk("rdata", RDATA, edata);
            chk("rresp", RRESP, eresp);
            chk("arready_in_resp", ARREADY, 0);
            data = RDATA; resp = RRESP;
            @(posedge aclk); #1;
        end
        RREADY = 0;
    endtask

    initial begin
        logic [1:0]  r;
        logic [7:0]  p;
        logic [31:0] d;
        logic [1:0]  r2;
        logic [7:0]  p2;

        // Reset
        model_reset();
        areset = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            if (i > 0) begin
                chk("rst_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
                chk("rst_valid", {BVALID, RVALID}, 2'b00);
                chk("rst_reg_out", reg_out, 256'h0);
                chk("rst_pulse", reg_wr_pulse, 8'h0);
            end
            @(posedge aclk); #1;
        end
        areset = 0;
        run = 1;
        @(negedge aclk);
        chk("ready_after_rst", {AWREADY, WREADY, ARREADY}, 3'b111);
        @(posedge aclk); #1;

        // Full write then read
        wr(12'h004, 32'hDEADBEEF, 4'hF, 0, 0, 0, r, p);
        chk("t2_bresp", r, 2'b00);
        chk("t2_pulse", p, 8'h02);
        chk("t2_reg1", reg_out[63:32], 32'hDEADBEEF);
        rd(12'h004, 0, 0, d, r);
        chk("t2_rdata", d, 32'hDEADBEEF);

        // Decoupled channels with strobes
        wr(12'h008, 32'h1122_3344, 4'b0101, 3, 0, 0, r, p);
        chk("t3_reg2", reg_out[95:64], 32'h0022_0044);
        wr(12'h008, 32'hAABB_CCDD, 4'b1010, 0, 3, 0, r, p);
        chk("t3_reg2b", reg_out[95:64], 32'hAA22_CC44);
        wr(12'h010, 32'h5555_5555, 4'b0000, 0, 0, 0, r, p);
        chk("t3_zero_strb_pulse", p, 8'h10);

        // Errors
        wr(12'h01C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r, p);
        chk("t4_ro_resp", r, 2'b10);
        chk("t4_ro_pulse", p, 8'h00);
        wr(12'h020, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, r, p);
        chk("t4_oor_resp", r, 2'b10);
        wr(12'h006, 32'hFFFF_FFFF, 4'hF, 0, 1, 0, r, p);
        chk("t4_mis_resp", r, 2'b10);
        rd(12'h020, 0, 0, d, r);
        chk("t4_rd_oor", {d, r}, {32'h0, 2'b10});
        status_in = 32'hA5A5_0001;
        rd(12'h01C, 0, 0, d, r);
        chk("t4_status", {d, r}, {32'hA5A5_0001, 2'b00});

        // Backpressure
        wr(12'h014, 32'h0BAD_F00D, 4'hF, 0, 0, 5, r, p);
        rd(12'h014, 0, 5, d, r);
        chk("t5_rdata", d, 32'h0BAD_F00D);

        // Collision on reg3
        wr(12'h00C, 32'h1234_5678, 4'hF, 0, 0, 0, r, p);
        fork
            wr(12'h00C, 32'hCAFE_F00D, 4'hF, 0, 0, 0, r2, p2);
            rd(12'h00C, 0, 0, d, r);
        join
        chk("t6_collide_old", d, 32'h1234_5678);
        chk("t6_collide_new", reg_out[127:96], 32'hCAFE_F00D);

        // Reset while only AW has been accepted
        AWADDR = 12'h010; AWVALID = 1;
        @(posedge aclk); #1;
        AWVALID = 0;
        areset = 1; WVALID = 1; WDATA = 32'h7777_7777; WSTRB = 4'hF;
        model_reset();
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        areset = 0; WVALID = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            chk("t6_no_bvalid", BVALID, 0);
            @(posedge aclk); #1;
        end

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            logic [11:0] a1, a2;
            int op;
            status_in = $urandom;
            a1 = 12'($urandom_range(0, 9) * 4);
            a2 = 12'($urandom_range(0, 9) * 4);
            if ($urandom_range(0, 7) == 0) a1 = a1 + 12'($urandom_range(1, 3));
            op = $urandom_range(0, 2);
            if (op == 0)
                wr(a1, $urandom, 4'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), r, p);
            else if (op == 1)
                rd(a1, $urandom_range(0, 2), $urandom_range(0, 3), d, r);
            else
                fork
                    wr(a1, $urandom, 4'($urandom), $urandom_range(0, 2),
                       $urandom_range(0, 2), $urandom_range(0, 2), r2, p2);
                    rd(a2, $urandom_range(0, 2), $urandom_range(0, 2), d, r);
                join
        end

        @(posedge aclk); #1;
        run = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
